// File: rtl/pdh_cmd_pkg.sv
// pdh_cmd_pkg: shared types, default word layout and helper functions for the
// PDH command register file and its benches.
package pdh_cmd_pkg;

    typedef enum logic [3:0] {
        CMD_NOP    = 4'd0,
        CMD_WRITE  = 4'd1,
        CMD_READ   = 4'd2,
        CMD_SET    = 4'd3,
        CMD_CLR    = 4'd4,
        CMD_STATUS = 4'd5
    } cmd_t;

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        EXEC,
        WAIT_LOW
    } state_t;

    // Default GPIO word layout (WORD_W=32, CMD_W=4)
    localparam int PDH_WORD_W   = 32;
    localparam int PDH_CMD_W    = 4;
    localparam int PDH_DATA_W   = PDH_WORD_W - 2 - PDH_CMD_W;
    localparam int PDH_SRST_BIT = PDH_WORD_W - 1;
    localparam int PDH_STB_BIT  = PDH_WORD_W - 2;
    localparam int PDH_CMD_HI   = PDH_WORD_W - 3;
    localparam int PDH_ACK_BIT  = PDH_WORD_W - 1 - PDH_CMD_W;
    localparam int PDH_ERR_BIT  = PDH_ACK_BIT - 1;

    typedef struct packed {
        logic [PDH_CMD_W-1:0]  cmd;
        logic                  ack;
        logic                  err;
        logic [PDH_DATA_W-1:0] payload;
    } cb_t;

    // Build a PS->PL command word in the default layout
    function automatic logic [PDH_WORD_W-1:0] make_word(
        input logic                  srst,
        input logic                  stb,
        input logic [PDH_CMD_W-1:0]  cmd,
        input logic [PDH_DATA_W-1:0] data
    );
        return {srst, stb, cmd, data};
    endfunction

    // Split a PL->PS callback word into its fields
    function automatic cb_t parse_cb(input logic [PDH_WORD_W-1:0] w);
        return cb_t'(w);
    endfunction

endpackage

// File: rtl/pdh_cmd_sync.sv
// pdh_cmd_sync: N-bit two-flop synchroniser for the PS GPIO word when the PS
// side runs on an unrelated clock.
module pdh_cmd_sync #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;

    // Two back-to-back flops; the first may go metastable, the second settles it
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/pdh_cmd_regfile.sv
// pdh_cmd_regfile: decodes the PS->PL GPIO command word through a four-phase
// strobe/ack handshake, executes it against NUM_REGS control registers and
// returns a callback word on the PL->PS GPIO.
// Optional: define PDH_CMD_SYNC_EN to put a two-flop synchroniser in front of
// the input register (result latency grows from 2 to 4 cycles).
module pdh_cmd_regfile
    import pdh_cmd_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int CMD_W    = 4,
    parameter int NUM_REGS = 8,
    parameter int REG_W    = 16,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_ni,
    input  logic [WORD_W-1:0]         axi_from_ps_i,
    output logic [WORD_W-1:0]         axi_to_ps_o,
    output logic [NUM_REGS*REG_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]       reg_upd_o,
    output logic                      busy_o
);

    localparam int DATA_W  = WORD_W - 2 - CMD_W;
    localparam int ADDR_W  = $clog2(NUM_REGS);
    localparam int ACK_BIT = WORD_W - 1 - CMD_W;

    if (ADDR_W + REG_W > DATA_W) begin : g_bad_width
        $error("pdh_cmd_regfile: ADDR_W+REG_W exceeds DATA_W");
    end
    if (NUM_REGS < 2 || (1 << ADDR_W) != NUM_REGS) begin : g_bad_regs
        $error("pdh_cmd_regfile: NUM_REGS must be a power of 2, at least 2");
    end
    if (2 * CNT_W > DATA_W) begin : g_bad_cnt
        $error("pdh_cmd_regfile: status counters do not fit the payload");
    end

    // Input path: optional synchroniser, then the word_q capture register
    logic [WORD_W-1:0] word_s;
`ifdef PDH_CMD_SYNC_EN
    localparam int STAGES = 3;
    pdh_cmd_sync #(.W(WORD_W)) u_sync (
        .clk    (clk),
        .rst_ni (rst_ni),
        .d      (axi_from_ps_i),
        .q      (word_s)
    );
`else
    localparam int STAGES = 1;
    assign word_s = axi_from_ps_i;
`endif

    logic [WORD_W-1:0] word_q;
    // vld_pipe tracks how far real input has propagated since reset, so ARM
    // never mistakes the reset-zeroed pipeline for a released strobe
    logic [STAGES-1:0] vld_pipe;

    // Capture the (possibly synchronised) command word
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q   <= '0;
            vld_pipe <= '0;
        end else begin
            word_q   <= word_s;
            vld_pipe <= (vld_pipe << 1) | STAGES'(1);
        end
    end

    logic              srst_q, stb_q, word_vld;
    logic [CMD_W-1:0]  cmd_q;
    logic [DATA_W-1:0] data_q;
    assign srst_q   = word_q[WORD_W-1];
    assign stb_q    = word_q[WORD_W-2];
    assign cmd_q    = word_q[WORD_W-3 -: CMD_W];
    assign data_q   = word_q[DATA_W-1:0];
    assign word_vld = vld_pipe[STAGES-1];

    state_t                        state_q;
    logic [CMD_W-1:0]              cmd_l;
    logic [DATA_W-1:0]             data_l;
    logic [NUM_REGS-1:0][REG_W-1:0] regs_q;
    logic [NUM_REGS-1:0]           upd_q;
    logic [CNT_W-1:0]              cmd_cnt_q, err_cnt_q;
    logic [WORD_W-1:0]             cb_q;

    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  val;
    assign addr = data_l[DATA_W-1 -: ADDR_W];
    assign val  = data_l[REG_W-1:0];

    // Middle data bits carry no meaning for this register map
    logic unused_data;
    assign unused_data = ^data_l;

    logic [REG_W-1:0]  nxt_val;
    logic              exec_wr, exec_err;
    logic [DATA_W-1:0] payload;

    // Result of the latched command against the addressed register
    always_comb begin
        nxt_val  = regs_q[addr];
        exec_wr  = 1'b0;
        exec_err = 1'b0;
        payload  = '0;
        case (cmd_l)
            CMD_W'(CMD_NOP): ;
            CMD_W'(CMD_WRITE): begin
                nxt_val = val;
                exec_wr = 1'b1;
                payload = DATA_W'(val);
            end
            CMD_W'(CMD_READ):
                payload = DATA_W'(regs_q[addr]);
            CMD_W'(CMD_SET): begin
                nxt_val = regs_q[addr] | val;
                exec_wr = 1'b1;
                payload = DATA_W'(regs_q[addr] | val);
            end
            CMD_W'(CMD_CLR): begin
                nxt_val = regs_q[addr] & ~val;
                exec_wr = 1'b1;
                payload = DATA_W'(regs_q[addr] & ~val);
            end
            CMD_W'(CMD_STATUS):
                payload = DATA_W'({err_cnt_q, cmd_cnt_q});
            default:
                exec_err = 1'b1;
        endcase
    end

    // Handshake FSM, register bank, counters and callback; soft reset wins
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARM;
            cmd_l     <= '0;
            data_l    <= '0;
            regs_q    <= '0;
            upd_q     <= '0;
            cmd_cnt_q <= '0;
            err_cnt_q <= '0;
            cb_q      <= '0;
        end else if (srst_q) begin
            state_q   <= ARM;
            regs_q    <= '0;
            upd_q     <= '0;
            cmd_cnt_q <= '0;
            err_cnt_q <= '0;
            cb_q      <= '0;
        end else begin
            upd_q <= '0;
            case (state_q)
                ARM: begin
                    if (word_vld && !stb_q) state_q <= IDLE;
                end
                IDLE: begin
                    if (stb_q) begin
                        cmd_l   <= cmd_q;
                        data_l  <= data_q;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    regs_q[addr] <= nxt_val;
                    if (exec_wr) upd_q[addr] <= 1'b1;
                    cmd_cnt_q <= cmd_cnt_q + CNT_W'(1);
                    if (exec_err && err_cnt_q != '1)
                        err_cnt_q <= err_cnt_q + CNT_W'(1);
                    cb_q    <= {cmd_l, 1'b1, exec_err, payload};
                    state_q <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!stb_q) begin
                        cb_q[ACK_BIT] <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= ARM;
            endcase
        end
    end

    assign axi_to_ps_o = cb_q;
    assign regs_o      = regs_q;
    assign reg_upd_o   = upd_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: doc/pdh_cmd_regfile.md
Name: pdh_cmd_regfile

Overview:
- Parametrised successor to the single-register LED/DAC command decoder inside pdh_core.
- Decodes the PS→PL GPIO command word (soft-rst, strobe, cmd, data) through a four-phase strobe/ack handshake.
- Executes commands against a bank of NUM_REGS control registers and returns a callback word on the PL→PS GPIO.
- Sits between the AXI GPIO and the PDH datapath; its register outputs drive LED, DAC setpoints, gains, etc.

Parameters:
- WORD_W, 32: GPIO word width. Layout: [WORD_W-1] soft rst, [WORD_W-2] strobe, next CMD_W bits cmd, remaining DATA_W = WORD_W-2-CMD_W bits data.
- CMD_W, 4: opcode width.
- NUM_REGS, 8: number of control registers, power of 2. ADDR_W = $clog2(NUM_REGS).
- REG_W, 16: register width. Elaboration error if ADDR_W+REG_W > DATA_W.
- CNT_W, 8: width of the command and error counters.

Ports:
- clk  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- axi_from_ps_i  in  WORD_W  command word from PS
- axi_to_ps_o  out  WORD_W  callback word to PS
- regs_o  out  NUM_REGS*REG_W  flattened registers; reg i at [i*REG_W +: REG_W]
- reg_upd_o  out  NUM_REGS  one-cycle pulse per register written, set or cleared
- busy_o  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst_ni=0, async): all regs 0, counters 0, axi_to_ps_o 0, reg_upd_o 0, FSM=ARM.
- Input word is registered once into word_q. All decode uses word_q.
- FSM states:
  - ARM: wait for strobe_q=0, then go to IDLE. This stops a strobe stuck high after reset from executing.
  - IDLE: if strobe_q=1, latch cmd/data into cmd_l/data_l and go to EXEC.
  - EXEC: perform the op for one cycle. Update regs, reg_upd_o, and the callback. Set ack=1. Go to WAIT_LOW.
  - WAIT_LOW: hold ack=1 while strobe_q=1. When strobe_q=0, clear ack and go to IDLE.
- Timing: strobe rises at input at edge k, is seen in word_q at k, EXEC runs at k+1, and regs/callback/ack are visible after edge k+2. Result latency is 2 cycles.
- cmd/data changes while strobe is high are ignored; only the latched values are used.
- Addressing: addr = data_l[DATA_W-1 -: ADDR_W]; val = data_l[REG_W-1:0].
- Opcodes:
  - 0 NOP: ack only.
  - 1 WRITE: reg[addr] = val.
  - 2 READ: no change.
  - 3 SET: reg |= val.
  - 4 CLR: reg &= ~val.
  - 5 STATUS: no change.
  - 6..15: illegal. No register change, err=1.
- reg_upd_o[addr] pulses in EXEC for WRITE/SET/CLR only, even if the value is unchanged.
- Callback word: [WORD_W-1 -: CMD_W] = cmd_l; bit below = ack; next bit = err; low DATA_W bits = payload.
  - Payload for WRITE/READ/SET/CLR: resulting reg[addr], zero-extended.
  - Payload for STATUS: {err_cnt, cmd_cnt}, zero-extended.
  - Payload for NOP/illegal: 0.
  - Callback holds until the next EXEC; only the ack bit falls in WAIT_LOW.
- Counters: cmd_cnt increments on every EXEC and wraps. err_cnt increments on illegal opcodes and saturates at all-ones. STATUS reports counts before its own increment.
- Soft reset: word_q soft-rst=1 overrides everything, in any state, including mid-handshake. Regs, counters, and callback clear; reg_upd_o=0; FSM goes to ARM. Regs stay cleared while the bit is held.
- Simultaneous soft-rst and strobe: soft-rst wins and the command is dropped.

Optional Feature:
- Macro: PDH_CMD_SYNC_EN.
- When defined: axi_from_ps_i passes through a 2-flop synchroniser before word_q, for a PS GPIO on an unrelated clock. Result latency becomes 4 cycles. ARM/handshake semantics are unchanged.
- When undefined: single register stage, 2-cycle latency.

Decomposition:
- Package pdh_cmd_pkg holds:
  - cmd_t enum (CMD_NOP, CMD_WRITE, CMD_READ, CMD_SET, CMD_CLR, CMD_STATUS);
  - state_t enum (ARM, IDLE, EXEC, WAIT_LOW);
  - bit-position localparams for the word layout;
  - make_word/parse-callback functions shared with the benches.
- One sub-module, pdh_cmd_sync: an N-bit 2-flop synchroniser, instantiated only under PDH_CMD_SYNC_EN.

Test Plan:
- Reset with strobe held high, then release rst_ni → no register change and ack=0. Drop the strobe, then strobe a WRITE → executes normally.
- WRITE addr 3, val 0x00AA with a two-step strobe → regs_o reg3=0x00AA, reg_upd_o[3] pulses exactly 1 cycle, callback {1,ack=1,err=0,0xAA}. After strobe falls, ack=0.
- SET 0x0F00 then CLR 0x000A on addr 3 → callbacks 0x0FAA then 0x0FA0.
- Opcode 9 → err=1, payload 0, regs unchanged. STATUS then returns err_cnt=1, cmd_cnt=4.
- Change data while strobe is high during WAIT_LOW → ignored, no second execution. Assert soft-rst mid-WAIT_LOW → all regs 0, callback 0, FSM=ARM.
- With PDH_CMD_SYNC_EN: a WRITE shows the register update 2 cycles later than the non-sync build.
